// File: rtl/flash_rd_arbiter.sv
// rtl/flash_rd_arbiter.sv - two-port read arbiter and sequencer for the shared 16-bit flash bus
// Optional single-entry word cache: define FLASH_RD_ARB_CACHE_EN.
module flash_rd_arbiter #(
  parameter int ADDR_W      = 22,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W:0]   m0_addr,
  output logic              m0_ack,
  output logic [7:0]        m0_data,
  input  logic              m1_req,
  input  logic [ADDR_W:0]   m1_addr,
  output logic              m1_ack,
  output logic [7:0]        m1_data,
  output logic [ADDR_W-1:0] flash_a,
  input  logic [15:0]       flash_d,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_adv_n,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
`ifdef FLASH_RD_ARB_CACHE_EN
    , S_HIT
`endif
  } state_t;

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            next_state;
  logic [3:0]        cnt;
  logic              grant;
  logic              last_grant;
  logic              byte_sel;
  logic              pick1;
  logic [ADDR_W:0]   sel_addr;
  logic [15:0]       word;
  logic [7:0]        rd_byte;
`ifdef FLASH_RD_ARB_CACHE_EN
  logic              hit;
  logic [ADDR_W-1:0] cache_tag;
  logic [15:0]       cache_data;
  logic              cache_valid;
`endif

  always_comb begin
    // Round-robin: on a tie the port that did not win last time is served.
    pick1    = m1_req && (!m0_req || !last_grant);
    sel_addr = pick1 ? m1_addr : m0_addr;
    word     = flash_d;
`ifdef FLASH_RD_ARB_CACHE_EN
    hit = cache_valid && (cache_tag == sel_addr[ADDR_W:1]);
    if (state == S_HIT) word = cache_data;
`endif
    rd_byte    = byte_sel ? word[15:8] : word[7:0];
    next_state = state;
    case (state)
      S_IDLE: begin
        if (m0_req || m1_req) begin
`ifdef FLASH_RD_ARB_CACHE_EN
          next_state = hit ? S_HIT : S_LAUNCH;
`else
          next_state = S_LAUNCH;
`endif
        end
      end
      S_LAUNCH: next_state = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT:   if (cnt == 4'd0) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
`ifdef FLASH_RD_ARB_CACHE_EN
      S_HIT:    next_state = S_DONE;
`endif
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      byte_sel    <= 1'b0;
      flash_a     <= '0;
      flash_ce_n  <= 1'b1;
      flash_oe_n  <= 1'b1;
      flash_adv_n <= 1'b1;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_data     <= 8'h00;
      m1_data     <= 8'h00;
      busy        <= 1'b0;
`ifdef FLASH_RD_ARB_CACHE_EN
      cache_tag   <= '0;
      cache_data  <= 16'h0000;
      cache_valid <= 1'b0;
`endif
    end else begin
      state       <= next_state;
      busy        <= (next_state != S_IDLE);
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      flash_adv_n <= 1'b1;
      if (state == S_IDLE && next_state != S_IDLE) begin
        grant    <= pick1;
        byte_sel <= sel_addr[0];
      end
      if (state == S_IDLE && next_state == S_LAUNCH) begin
        flash_a     <= sel_addr[ADDR_W:1];
        flash_ce_n  <= 1'b0;
        flash_oe_n  <= 1'b0;
        flash_adv_n <= 1'b0;
      end
      if (state == S_LAUNCH) cnt <= WAIT_LAST;
      else if (state == S_WAIT) cnt <= cnt - 4'd1;
      // Capture edge: flash_d is sampled here and the strobes released.
      if (next_state == S_DONE) begin
        flash_ce_n <= 1'b1;
        flash_oe_n <= 1'b1;
        last_grant <= grant;
        if (grant) begin
          m1_ack  <= 1'b1;
          m1_data <= rd_byte;
        end else begin
          m0_ack  <= 1'b1;
          m0_data <= rd_byte;
        end
`ifdef FLASH_RD_ARB_CACHE_EN
        if (state != S_HIT) begin
          cache_tag   <= flash_a;
          cache_data  <= flash_d;
          cache_valid <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_flash_rd_arbiter.sv
// tb/tb_flash_rd_arbiter.sv - directed self-checking bench for flash_rd_arbiter
// Main instance uses WAIT_CYCLES=2; a second instance uses WAIT_CYCLES=0.
module tb_flash_rd_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m1_req, m0_ack, m1_ack;
  logic [22:0] m0_addr, m1_addr;
  logic [7:0]  m0_data, m1_data;
  logic [21:0] flash_a;
  logic [15:0] flash_d;
  logic        ce_n, oe_n, adv_n, busy;

  logic        z_m0_req, z_m1_req, z_m0_ack, z_m1_ack;
  logic [22:0] z_m0_addr, z_m1_addr;
  logic [7:0]  z_m0_data, z_m1_data;
  logic [21:0] z_flash_a;
  logic [15:0] z_flash_d;
  logic        z_ce_n, z_oe_n, z_adv_n, z_busy;

  int errors = 0;
  int checks = 0;
  int m0_ack_seen = 0;

  flash_rd_arbiter #(.ADDR_W(22), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_data(m0_data),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_ack(m1_ack), .m1_data(m1_data),
    .flash_a(flash_a), .flash_d(flash_d), .flash_ce_n(ce_n), .flash_oe_n(oe_n),
    .flash_adv_n(adv_n), .busy(busy)
  );

  flash_rd_arbiter #(.ADDR_W(22), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(z_m0_req), .m0_addr(z_m0_addr), .m0_ack(z_m0_ack), .m0_data(z_m0_data),
    .m1_req(z_m1_req), .m1_addr(z_m1_addr), .m1_ack(z_m1_ack), .m1_data(z_m1_data),
    .flash_a(z_flash_a), .flash_d(z_flash_d), .flash_ce_n(z_ce_n), .flash_oe_n(z_oe_n),
    .flash_adv_n(z_adv_n), .busy(z_busy)
  );

  always @(negedge clk) if (m0_ack) m0_ack_seen++;

  task automatic run_read(input bit port, input logic [22:0] addr, input logic [15:0] d,
                          output int lat, output logic [7:0] data, output int adv_lo,
                          output int ce_lo, output logic [21:0] fa);
    lat = 0; data = 8'h00; adv_lo = 0; ce_lo = 0; fa = '0;
    @(posedge clk); #1;
    flash_d = d;
    if (port) begin m1_addr = addr; m1_req = 1'b1; end
    else begin m0_addr = addr; m0_req = 1'b1; end
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (!adv_n) begin adv_lo++; fa = flash_a; end
      if (!ce_n) ce_lo++;
      if (port ? m1_ack : m0_ack) begin
        lat = k;
        data = port ? m1_data : m0_data;
        break;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 0; m1_req = 0; m0_addr = '0; m1_addr = '0; flash_d = '0;
    z_m0_req = 0; z_m1_req = 0; z_m0_addr = '0; z_m1_addr = '0; z_flash_d = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (flash_a !== 22'd0) begin errors++; $display("FAIL reset_flash_a: got %h want 0", flash_a); end
    checks++; if (ce_n !== 1'b1) begin errors++; $display("FAIL reset_ce_n: got %b want 1", ce_n); end
    checks++; if (oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b want 1", oe_n); end
    checks++; if (adv_n !== 1'b1) begin errors++; $display("FAIL reset_adv_n: got %b want 1", adv_n); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL reset_m0_ack: got %b want 0", m0_ack); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL reset_m1_ack: got %b want 0", m1_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (m0_data !== 8'h00) begin errors++; $display("FAIL reset_m0_data: got %h want 00", m0_data); end
    checks++; if (m1_data !== 8'h00) begin errors++; $display("FAIL reset_m1_data: got %h want 00", m1_data); end
  endtask

  task automatic test_single_read();
    int lat, adv_lo, ce_lo;
    logic [7:0] data;
    logic [21:0] fa;
    run_read(1'b0, 23'h000101, 16'hA55A, lat, data, adv_lo, ce_lo, fa);
    checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency: got %0d want 4", lat); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_data_hi: got %h want a5", data); end
    checks++; if (adv_lo !== 1) begin errors++; $display("FAIL single_adv_cycles: got %0d want 1", adv_lo); end
    checks++; if (fa !== 22'h000080) begin errors++; $display("FAIL single_flash_a: got %h want 000080", fa); end
    checks++; if (ce_lo !== 3) begin errors++; $display("FAIL single_ce_cycles: got %0d want 3", ce_lo); end
    checks++; if (ce_n !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_done_strobes: got ce_n=%b busy=%b want 1 1", ce_n, busy); end
    run_read(1'b0, 23'h000100, 16'hA55A, lat, data, adv_lo, ce_lo, fa);
    checks++; if (data !== 8'h5A) begin errors++; $display("FAIL single_data_lo: got %h want 5a", data); end
  endtask

  task automatic test_round_robin();
    int seq[4];
    int at[4];
    int n;
    logic [7:0] d0, d1, m1_at_first;
    n = 0; d0 = 0; d1 = 0; m1_at_first = 8'hFF;
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    flash_d = 16'hA55A; m0_addr = 23'h000000; m1_addr = 23'h000003;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(posedge clk); #1;
      if (m0_ack) begin
        if (n == 0) begin d0 = m0_data; m1_at_first = m1_data; end
        seq[n] = 0; at[n] = k; n++;
      end else if (m1_ack) begin
        if (n == 1) d1 = m1_data;
        seq[n] = 1; at[n] = k; n++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_ack_count: got %0d want 4", n); end
    else begin
      checks++; if (seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 0 || seq[3] !== 1) begin
        errors++; $display("FAIL rr_order: got %0d%0d%0d%0d want 0101", seq[0], seq[1], seq[2], seq[3]); end
      checks++; if (at[0] !== 4) begin errors++; $display("FAIL rr_first_latency: got %0d want 4", at[0]); end
      checks++; if (at[1] - at[0] !== 5) begin errors++; $display("FAIL rr_spacing: got %0d want 5", at[1] - at[0]); end
    end
    checks++; if (d0 !== 8'h5A) begin errors++; $display("FAIL rr_port0_data: got %h want 5a", d0); end
    checks++; if (d1 !== 8'hA5) begin errors++; $display("FAIL rr_port1_data: got %h want a5", d1); end
    checks++; if (m1_at_first !== 8'h00) begin errors++; $display("FAIL rr_loser_untouched: got %h want 00", m1_at_first); end
  endtask

  task automatic test_reset_mid_access();
    int lat, acks_in_reset;
    lat = 0; acks_in_reset = 0;
    @(posedge clk); #1;
    m1_addr = 23'h000003; flash_d = 16'h1234; m1_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || ce_n !== 1'b0 || adv_n !== 1'b1) begin
      errors++; $display("FAIL mid_in_wait: got busy=%b ce_n=%b adv_n=%b want 1 0 1", busy, ce_n, adv_n); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++; if ({ce_n, oe_n, adv_n} !== 3'b111) begin errors++; $display("FAIL mid_rst_strobes: got %b want 111", {ce_n, oe_n, adv_n}); end
    checks++; if (flash_a !== 22'd0) begin errors++; $display("FAIL mid_rst_flash_a: got %h want 0", flash_a); end
    checks++; if (m1_data !== 8'h00 || m0_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h %h want 00 00", m0_data, m1_data); end
    repeat (2) begin @(posedge clk); #1; if (m1_ack || m0_ack) acks_in_reset++; end
    checks++; if (acks_in_reset !== 0) begin errors++; $display("FAIL mid_rst_no_ack: got %0d want 0", acks_in_reset); end
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (m1_ack) begin lat = k; break; end
    end
    m1_req = 1'b0;
    checks++; if (lat !== 4) begin errors++; $display("FAIL mid_resume_latency: got %0d want 4", lat); end
    checks++; if (m1_data !== 8'h12) begin errors++; $display("FAIL mid_resume_data: got %h want 12", m1_data); end
  endtask

  task automatic test_back_to_back();
    int lat, adv_lo, ce_lo, base;
    logic [7:0] data;
    logic [21:0] fa;
    base = m0_ack_seen;
    run_read(1'b0, 23'h000010, 16'h3C4B, lat, data, adv_lo, ce_lo, fa);
    checks++; if (data !== 8'h4B) begin errors++; $display("FAIL b2b_data0: got %h want 4b", data); end
    run_read(1'b0, 23'h000013, 16'h7E81, lat, data, adv_lo, ce_lo, fa);
    checks++; if (data !== 8'h7E) begin errors++; $display("FAIL b2b_data1: got %h want 7e", data); end
    run_read(1'b0, 23'h000020, 16'h0FF0, lat, data, adv_lo, ce_lo, fa);
    checks++; if (data !== 8'hF0) begin errors++; $display("FAIL b2b_data2: got %h want f0", data); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (m0_ack_seen - base !== 3) begin errors++; $display("FAIL b2b_ack_count: got %0d want 3", m0_ack_seen - base); end
    checks++; if (m1_data !== 8'h12) begin errors++; $display("FAIL b2b_port1_untouched: got %h want 12", m1_data); end
  endtask

  task automatic test_wait0();
    int lat, oe_lo;
    lat = 0; oe_lo = 0;
    @(posedge clk); #1;
    z_m0_addr = 23'h000005; z_flash_d = 16'hBEEF; z_m0_req = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (!z_oe_n) oe_lo++;
      if (z_m0_ack) begin lat = k; break; end
    end
    z_m0_req = 1'b0;
    checks++; if (lat !== 2) begin errors++; $display("FAIL w0_latency: got %0d want 2", lat); end
    checks++; if (oe_lo !== 1) begin errors++; $display("FAIL w0_oe_cycles: got %0d want 1", oe_lo); end
    checks++; if (z_m0_data !== 8'hBE) begin errors++; $display("FAIL w0_data: got %h want be", z_m0_data); end
  endtask

`ifdef FLASH_RD_ARB_CACHE_EN
  task automatic test_cache();
    int lat, adv_lo, ce_lo;
    logic [7:0] data;
    logic [21:0] fa;
    run_read(1'b0, 23'h000200, 16'hC3D4, lat, data, adv_lo, ce_lo, fa);
    checks++; if (lat !== 4 || data !== 8'hD4) begin errors++; $display("FAIL cache_fill: got lat=%0d data=%h want 4 d4", lat, data); end
    run_read(1'b0, 23'h000201, 16'h0000, lat, data, adv_lo, ce_lo, fa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL cache_hit_latency: got %0d want 2", lat); end
    checks++; if (ce_lo !== 0) begin errors++; $display("FAIL cache_hit_ce: got %0d want 0", ce_lo); end
    checks++; if (data !== 8'hC3) begin errors++; $display("FAIL cache_hit_data: got %h want c3", data); end
    run_read(1'b0, 23'h000400, 16'h9876, lat, data, adv_lo, ce_lo, fa);
    checks++; if (lat !== 4 || ce_lo !== 3 || data !== 8'h76) begin
      errors++; $display("FAIL cache_miss: got lat=%0d ce=%0d data=%h want 4 3 76", lat, ce_lo, data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_reset_mid_access();
    test_back_to_back();
    test_wait0();
`ifdef FLASH_RD_ARB_CACHE_EN
    test_cache();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flash_rd_arbiter.md
# flash_rd_arbiter

Read-only arbiter and sequencer for the shared 16-bit parallel flash bus. It serves two byte-wide requesters over a level-request / pulse-acknowledge handshake. Port 0 is the Game Boy cartridge ROM path; port 1 is the debugger memory viewer and ROM loader. The block drives address, chip-enable, output-enable and address-valid with a programmable wait-state count, and returns the selected byte from each 16-bit word.

## Interface
- `ADDR_W`, 22: flash word-address width; byte address width is `ADDR_W+1`.
- `WAIT_CYCLES`, 2: extra clk cycles between address launch and data capture (0–15).
- `clk` in 1: memory clock (16 MHz domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `m0_req` in 1: port 0 read request; level, held until `m0_ack`.
- `m0_addr` in `ADDR_W+1`: port 0 byte address; stable while `m0_req`.
- `m0_ack` out 1: one-cycle pulse; `m0_data` is valid in the same cycle.
- `m0_data` out 8: port 0 read byte; holds until the next port 0 ack.
- `m1_req`, `m1_addr`, `m1_ack`, `m1_data`: same as port 0, for port 1.
- `flash_a` out `ADDR_W`: word address, equal to `addr[ADDR_W:1]`.
- `flash_d` in 16: flash data.
- `flash_ce_n` out 1: chip enable, active low.
- `flash_oe_n` out 1: output enable, active low.
- `flash_adv_n` out 1: address valid, active low, low for the launch cycle only.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, plus HIT when cache is enabled.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one port requests, grant it.
  - If both request, grant the port not recorded in `last_grant` (round-robin).
  - Latch the grantee and its address. Go to LAUNCH, or to HIT on a cache hit.
- LAUNCH:
  - `flash_a` is driven from the latched address.
  - `flash_ce_n` = 0, `flash_oe_n` = 0, `flash_adv_n` = 0.
  - Next state is WAIT, or DONE when `WAIT_CYCLES` = 0.
- WAIT:
  - A 4-bit counter counts `WAIT_CYCLES`.
  - `flash_ce_n` and `flash_oe_n` stay low; `flash_adv_n` = 1; `flash_a` is held.
  - On the last count, go to DONE.
- DONE:
  - `flash_d` is registered on the edge entering DONE.
  - The grantee's data register loads `d[15:8]` if `addr[0]` = 1, else `d[7:0]`.
  - The grantee's ack is high for this one cycle; `last_grant` updates to the grantee.
  - Next state is IDLE.
- Handshake rule: the requester drops `req` at the edge ending its ack cycle. A `req` still high in IDLE is a new request.
- The non-granted port's request waits and is never lost. Its ack and data registers are untouched.
- Flash is never written; the block has no write port.

## Timing
- Reset values:
  - State IDLE, `last_grant` = 1 (port 0 wins the first tie).
  - `flash_a` = 0; `flash_ce_n`, `flash_oe_n`, `flash_adv_n` = 1.
  - `m0_ack`, `m1_ack`, `busy` = 0; `m0_data`, `m1_data` = 0x00.
- Miss latency: from the IDLE edge that samples `req` to the ack cycle is `WAIT_CYCLES+2` edges. The default is 4 cycles, i.e. ack is visible 4 cycles after the request is sampled.
- Throughput: one access per `WAIT_CYCLES+3` cycles, because IDLE costs one cycle between accesses.
- Tie at IDLE: exactly one grant. The loser is served in the immediately following access.
- Requests arriving while busy are sampled at the next IDLE.
- Reset asserted mid-access:
  - The block returns to the reset values immediately and emits no ack.
  - Pending requesters re-arbitrate after `rst_n` deasserts.
- All outputs are registered; no combinational path runs from `req` to `ack`.

## Configuration
- `FLASH_RD_ARB_CACHE_EN` defined:
  - Adds a single shared cache entry: tag = last fetched word address, 16-bit data, valid bit.
  - The entry is filled in DONE; valid clears on reset.
  - A request in IDLE whose word address equals the tag while valid goes to HIT.
  - HIT asserts no flash strobes and acks one cycle later with byte selection from the cached word. Hit latency is 2 edges.
  - `last_grant` updates on hits too.
- `FLASH_RD_ARB_CACHE_EN` undefined: there is no HIT state and every request performs a flash access.

## Test plan
- Single port 0 read, `WAIT_CYCLES`=2, `m0_addr`=0x000101, `flash_d`=0xA55A:
  - `flash_a`=0x000080 with `flash_adv_n` low for one cycle.
  - `m0_ack` at cycle +4 with `m0_data`=0xA5.
  - The same read at 0x000100 returns 0x5A.
- Simultaneous `m0_req`/`m1_req` out of reset:
  - Port 0 is acked first, then port 1 in the next access.
  - With both held continuously, grants alternate 0,1,0,1.
- `WAIT_CYCLES`=0:
  - LAUNCH goes directly to DONE; ack arrives 2 cycles after sampling.
  - `flash_oe_n` is low for exactly 1 cycle.
- Reset pulse during WAIT:
  - All outputs return to their reset values the same cycle; no ack is emitted.
  - After release, the still-held `m1_req` completes normally.
- Cache enabled:
  - Read 0x000200, then 0x000201: the second read shows no `flash_ce_n` activity, acks after 2 cycles and returns the high byte.
  - A subsequent read at 0x000400 misses and performs a full access.
- Back-to-back port 0 requests with `req` dropped at ack: exactly one ack per request, with no duplicate ack.
